capture_controller: RTL

- Per-channel interval timer and result scheduler that sits downstream of the edge detector.
- Consumes one-cycle rising-edge pulses (start, capture, reset-capture) for NB_CAPTURES channels and runs one cycle counter per channel.
- Latches a count on each capture and arbitrates pending results round-robin onto a single valid/ready result port.

---
 rtl/capture_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/capture_controller.sv
// Per-channel interval timers with a round-robin result arbiter onto one valid/ready port.
// Define CAPTURE_SATURATE_EN to make channel counters saturate instead of wrapping.

module capture_channel #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_an_i,
    input  logic                 start_i,
    input  logic                 capture_i,
    input  logic                 clear_i,
    input  logic                 grant_i,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic                 pend_o,
    output logic [CNT_WIDTH-1:0] pend_val_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_an_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            cnt        <= '0;
            pend_o     <= 1'b0;
            pend_val_o <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            cnt        <= '0;
            pend_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            // A grant in this cycle frees the slot, so a coincident capture is not an overflow.
            if (capture_i && state == RUN) begin
                if (pend_o && !grant_i) begin
                    overflow_o <= 1'b1;
                end else begin
                    pend_o     <= 1'b1;
                    pend_val_o <= cnt;
                end
            end else if (grant_i) begin
                pend_o <= 1'b0;
            end

            if (start_i) begin
                state  <= RUN;
                busy_o <= 1'b1;
                cnt    <= '0;
            end else if (state == RUN) begin
`ifdef CAPTURE_SATURATE_EN
                if (cnt != '1) cnt <= cnt + 1'b1;
`else
                cnt <= cnt + 1'b1;
`endif
            end
        end
    end

endmodule

module capture_controller #(
    parameter int NB_CAPTURES = 10,
    parameter int CNT_WIDTH   = 16,
    parameter int CHAN_W      = (NB_CAPTURES > 1) ? $clog2(NB_CAPTURES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_an_i,
    input  logic [NB_CAPTURES-1:0] start_rise_i,
    input  logic [NB_CAPTURES-1:0] capture_rise_i,
    input  logic [NB_CAPTURES-1:0] rst_capture_rise_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [CHAN_W-1:0]      res_chan_o,
    output logic [CNT_WIDTH-1:0]   res_count_o,
    output logic [NB_CAPTURES-1:0] busy_o,
    output logic [NB_CAPTURES-1:0] overflow_o
);

    logic [NB_CAPTURES-1:0]                pend;
    logic [NB_CAPTURES-1:0]                gnt;
    logic [NB_CAPTURES-1:0][CNT_WIDTH-1:0] pend_val;
    logic [CHAN_W-1:0]                     ptr;
    logic [CHAN_W-1:0]                     gnt_idx;
    logic [CHAN_W-1:0]                     ptr_nxt;
    logic                                  gnt_found;
    logic                                  slot_free;

    for (genvar g = 0; g < NB_CAPTURES; g++) begin : g_chan
        capture_channel #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
            .clk_i      (clk_i),
            .rst_an_i   (rst_an_i),
            .start_i    (start_rise_i[g]),
            .capture_i  (capture_rise_i[g]),
            .clear_i    (rst_capture_rise_i[g]),
            .grant_i    (gnt[g]),
            .busy_o     (busy_o[g]),
            .overflow_o (overflow_o[g]),
            .pend_o     (pend[g]),
            .pend_val_o (pend_val[g])
        );
    end

    assign slot_free = !res_valid_o || res_ready_i;

    // First pending channel at or after ptr, scanning cyclically.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NB_CAPTURES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NB_CAPTURES) idx = idx - NB_CAPTURES;
            if (!gnt_found && pend[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = CHAN_W'(idx);
            end
        end
        gnt = '0;
        if (slot_free && gnt_found) gnt[gnt_idx] = 1'b1;
        ptr_nxt = (int'(gnt_idx) == NB_CAPTURES - 1) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_an_i) begin
            res_valid_o <= 1'b0;
            res_chan_o  <= '0;
            res_count_o <= '0;
            ptr         <= '0;
        end else if (slot_free) begin
            if (gnt_found) begin
                res_valid_o <= 1'b1;
                res_chan_o  <= gnt_idx;
                res_count_o <= pend_val[gnt_idx];
                ptr         <= ptr_nxt;
            end else begin
                res_valid_o <= 1'b0;
            end
        end
    end

endmodule
